prescaled_timer: RTL

Parametrised, prescaled up-counter timer. It generalises the team's free-running 4-bit counter with a configurable width, a clock prescaler and a programmable period. It supports one-shot and periodic modes, start/stop control, a count-enable and a registered expiry pulse. It sits beside the control logic in the tile and provides timeouts, periodic ticks and event pacing.

---
 rtl/prescaled_timer.sv | 102 ++++++++++
 1 files changed

// File: rtl/prescaled_timer.sv
// Prescaled up-counter timer with one-shot/periodic modes, start/stop control
// and a registered expiry pulse on each terminal-count wrap or finish.
module prescaled_timer #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  mode,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [WIDTH-1:0]      period,
    output logic [WIDTH-1:0]      count,
    output logic                  running,
    output logic                  done,
    output logic                  expired
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [PRESCALE_W-1:0] pcnt;
    logic [PRESCALE_W-1:0] prescale_lat;
    logic [WIDTH-1:0]      period_lat;
    logic                  mode_lat;
    logic                  tick;
    logic                  terminal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        tick       = 1'b0;
        terminal   = 1'b0;
        state_next = state;
        if (state == RUN && en && pcnt == prescale_lat) begin
            tick = 1'b1;
        end
        if (tick && count == period_lat) begin
            terminal = 1'b1;
        end
        // stop outranks start when both arrive together
        if (stop) begin
            state_next = IDLE;
        end else if (start) begin
            state_next = RUN;
        end else if (terminal && !mode_lat) begin
            state_next = DONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count        <= '0;
            pcnt         <= '0;
            prescale_lat <= '0;
            period_lat   <= '0;
            mode_lat     <= 1'b0;
            expired      <= 1'b0;
        end else begin
            expired <= 1'b0;
            if (stop) begin
                // count and prescaler hold their values
            end else if (start) begin
                count        <= '0;
                pcnt         <= '0;
                prescale_lat <= prescale;
                period_lat   <= period;
                mode_lat     <= mode;
            end else if (state == RUN && en) begin
                pcnt <= tick ? '0 : pcnt + 1'b1;
                if (tick) begin
                    if (count != period_lat) begin
                        count <= count + 1'b1;
                    end else begin
                        // one-shot leaves count parked at the terminal value
                        expired <= 1'b1;
                        if (mode_lat) begin
                            count <= '0;
                        end
                    end
                end
            end
        end
    end

    assign running = (state == RUN);
    assign done    = (state == DONE);

endmodule
